// File: rtl/sdrc_pkg.sv
// Shared definitions for the SDRAM-controller user-interface responder.
// This package holds the command encodings, the state encoding and the interface widths.
package sdrc_pkg;

    localparam int AddrWidth = 21;
    localparam int DataWidth = 32;
    localparam int DqmWidth  = 4;
    localparam int LenWidth  = 8;

    localparam logic [2:0] CmdMrs       = 3'b000;
    localparam logic [2:0] CmdRefresh   = 3'b001;
    localparam logic [2:0] CmdPrecharge = 3'b010;
    localparam logic [2:0] CmdActivate  = 3'b011;
    localparam logic [2:0] CmdWrite     = 3'b100;
    localparam logic [2:0] CmdRead      = 3'b101;
    localparam logic [2:0] CmdNop       = 3'b111;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StWrite,
        StReadWait,
        StRead,
        StBusy
    } state_t;

    // Encodings 110 and 111 both behave as NOP; everything at or below CmdRead gets acked.
    function automatic logic isAckedCmd(input logic [2:0] cmd);
        return (cmd <= CmdRead);
    endfunction

endpackage

// File: rtl/sdrc_responder_mem.sv
// Byte-enabled, single-port word array with a registered read port.
// The read register is cleared by reset, but the array contents are not cleared.
module sdrc_responder_mem
    import sdrc_pkg::*;
#(
    parameter int AddrBits = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_wrEn,
    input  logic                 i_rdEn,
    input  logic [AddrBits-1:0]  i_addr,
    input  logic [DataWidth-1:0] i_wrData,
    input  logic [DqmWidth-1:0]  i_byteEn,
    output logic [DataWidth-1:0] o_rdData
);

    logic [DataWidth-1:0] r_mem [0:(1<<AddrBits)-1];
    logic [DataWidth-1:0] r_rdData;

    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            for (int b = 0; b < DqmWidth; b++) begin
                if (i_byteEn[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wrData[8*b +: 8];
                end
            end
        end
    end

    // The read word is held between reads, so the last burst word stays visible on the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdData <= '0;
        end else if (i_rdEn) begin
            r_rdData <= r_mem[i_addr];
        end
    end

    assign o_rdData = r_rdData;

endmodule

// File: rtl/sdrc_responder.sv
// Behavioural stand-in for the SDRAM controller user interface, backed by an internal word array.
// It uses short, fixed init and command timing so that benches do not wait for SDRAM initialisation.
module sdrc_responder
    import sdrc_pkg::*;
#(
    parameter int MemAddressBitwidth = 16,
    parameter int InitCycles         = 16,
    parameter int ReadLatency        = 3,
    parameter int CmdBusyCycles      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 I_sdrc_cmd_en,
    input  logic [2:0]           I_sdrc_cmd,
    input  logic                 I_sdrc_precharge_ctrl,
    input  logic                 I_sdram_power_down,
    input  logic                 I_sdram_selfrefresh,
    input  logic [AddrWidth-1:0] I_sdrc_addr,
    input  logic [DqmWidth-1:0]  I_sdrc_dqm,
    input  logic [DataWidth-1:0] I_sdrc_data,
    input  logic [LenWidth-1:0]  I_sdrc_data_len,
    output logic [DataWidth-1:0] O_sdrc_data,
    output logic                 O_sdrc_init_done,
    output logic                 O_sdrc_cmd_ack,
    output logic                 read_valid
);

    localparam int CntWidth = 16;
    localparam logic [CntWidth-1:0] InitLast     = CntWidth'(InitCycles - 1);
    localparam logic [CntWidth-1:0] ReadWaitLoad = CntWidth'(ReadLatency - 1);
    localparam logic [CntWidth-1:0] BusyLoad     = CntWidth'(CmdBusyCycles - 1);

    state_t                        r_state;
    logic [CntWidth-1:0]           r_cnt;
    logic [LenWidth-1:0]           r_len;
    logic [MemAddressBitwidth-1:0] r_addr;
    logic                          r_initDone;
    logic                          r_ack;
    logic                          r_readValid;

    logic                          w_wrEn;
    logic                          w_rdEn;
    logic [DataWidth-1:0]          w_rdData;
    logic                          w_unused;

    assign w_unused = ^{I_sdrc_precharge_ctrl, I_sdram_power_down, I_sdram_selfrefresh,
                        I_sdrc_addr[AddrWidth-1:MemAddressBitwidth]};

    // Fetch one cycle before each word is due: the last wait cycle fetches word 0, and each READ cycle except the last fetches the next word.
    assign w_wrEn = (r_state == StWrite);
    assign w_rdEn = ((r_state == StReadWait) && (r_cnt == '0)) ||
                    ((r_state == StRead) && (r_cnt != '0));

    // r_cnt counts init cycles in INIT and remaining cycles or words in every other non-idle state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StInit;
            r_cnt       <= '0;
            r_len       <= '0;
            r_addr      <= '0;
            r_initDone  <= 1'b0;
            r_ack       <= 1'b0;
            r_readValid <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                StInit: begin
                    if (r_cnt == InitLast) begin
                        r_initDone <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StIdle: begin
                    if (I_sdrc_cmd_en && isAckedCmd(I_sdrc_cmd)) begin
                        r_ack  <= 1'b1;
                        r_addr <= I_sdrc_addr[MemAddressBitwidth-1:0];
                        r_len  <= I_sdrc_data_len;
                        if (I_sdrc_cmd == CmdWrite) begin
                            r_cnt   <= CntWidth'(I_sdrc_data_len);
                            r_state <= StWrite;
                        end else if (I_sdrc_cmd == CmdRead) begin
                            r_cnt   <= ReadWaitLoad;
                            r_state <= StReadWait;
                        end else begin
                            r_cnt   <= BusyLoad;
                            r_state <= StBusy;
                        end
                    end
                end
                StWrite: begin
                    r_addr <= r_addr + 1'b1;
                    if (r_cnt == '0) begin
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StReadWait: begin
                    if (r_cnt == '0) begin
                        r_addr      <= r_addr + 1'b1;
                        r_cnt       <= CntWidth'(r_len);
                        r_readValid <= 1'b1;
                        r_state     <= StRead;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StRead: begin
                    if (r_cnt == '0) begin
                        r_readValid <= 1'b0;
                        r_state     <= StIdle;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                        r_cnt  <= r_cnt - 1'b1;
                    end
                end
                StBusy: begin
                    if (r_cnt == '0) begin
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= StInit;
                end
            endcase
        end
    end

    sdrc_responder_mem #(
        .AddrBits (MemAddressBitwidth)
    ) u_mem (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_wrEn   (w_wrEn),
        .i_rdEn   (w_rdEn),
        .i_addr   (r_addr),
        .i_wrData (I_sdrc_data),
        .i_byteEn (~I_sdrc_dqm),
        .o_rdData (w_rdData)
    );

    assign O_sdrc_data      = w_rdData;
    assign O_sdrc_init_done = r_initDone;
    assign O_sdrc_cmd_ack   = r_ack;
    assign read_valid       = r_readValid;

endmodule

// File: tb/tb_sdrc_responder.sv
// Directed bench for sdrc_responder with the default parameters.
// It covers init timing, bursts, byte masks, address wrap, busy-window rejection and reset in the middle of a burst.
module tb_sdrc_responder;
    import sdrc_pkg::*;

    localparam int Init = 16;
    localparam int RL   = 3;
    localparam int Busy = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmdEn = 1'b0;
    logic [2:0]  cmd = CmdNop;
    logic [20:0] addr = '0;
    logic [3:0]  dqm = '0;
    logic [31:0] wData = '0;
    logic [7:0]  len = '0;
    logic [31:0] rData;
    logic        initDone;
    logic        ack;
    logic        rValid;

    int checks = 0;
    int failures = 0;

    logic [31:0] wrWords [0:7];
    logic [3:0]  wrMask [0:7];
    logic [31:0] expWords [0:7];

    typedef struct {
        logic        isWrite;
        logic [20:0] addr;
        logic [31:0] data;
        logic [3:0]  dqm;
        logic [31:0] expData;
        string       name;
    } vec_t;

    vec_t vecs [0:7];

    sdrc_responder #(
        .MemAddressBitwidth (16),
        .InitCycles         (Init),
        .ReadLatency        (RL),
        .CmdBusyCycles      (Busy)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .I_sdrc_cmd_en         (cmdEn),
        .I_sdrc_cmd            (cmd),
        .I_sdrc_precharge_ctrl (1'b0),
        .I_sdram_power_down    (1'b0),
        .I_sdram_selfrefresh   (1'b0),
        .I_sdrc_addr           (addr),
        .I_sdrc_dqm            (dqm),
        .I_sdrc_data           (wData),
        .I_sdrc_data_len       (len),
        .O_sdrc_data           (rData),
        .O_sdrc_init_done      (initDone),
        .O_sdrc_cmd_ack        (ack),
        .read_valid            (rValid)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] c, input logic [20:0] a, input logic [7:0] l);
        cmd   = c;
        addr  = a;
        len   = l;
        cmdEn = 1'b1;
    endtask

    // Issues the command in the current cycle and returns in the ack cycle.
    task automatic issueCmd(input logic [2:0] c, input logic [20:0] a, input logic [7:0] l, input string tag);
        applyStimulus(c, a, l);
        tick();
        cmdEn = 1'b0;
        checkOutput({tag, "_ack"}, {31'b0, ack}, 32'd1);
    endtask

    task automatic writeBurst(input logic [20:0] a, input logic [7:0] l, input string tag);
        issueCmd(CmdWrite, a, l, tag);
        for (int k = 0; k <= int'(l); k++) begin
            wData = wrWords[k];
            dqm   = wrMask[k];
            tick();
            if (k == 0) checkOutput({tag, "_ack_once"}, {31'b0, ack}, 32'd0);
        end
        wData = '0;
        dqm   = '0;
    endtask

    // A non-negative abortWord pulls rst_n low while that word is on the bus.
    task automatic readBurst(input logic [20:0] a, input logic [7:0] l, input int abortWord, input string tag);
        issueCmd(CmdRead, a, l, tag);
        checkOutput({tag, "_valid_wait"}, {31'b0, rValid}, 32'd0);
        for (int c = 1; c < RL; c++) begin
            tick();
            if (c == 1) checkOutput({tag, "_ack_once"}, {31'b0, ack}, 32'd0);
            checkOutput({tag, "_valid_wait"}, {31'b0, rValid}, 32'd0);
        end
        for (int k = 0; k <= int'(l); k++) begin
            tick();
            checkOutput($sformatf("%s_valid%0d", tag, k), {31'b0, rValid}, 32'd1);
            checkOutput($sformatf("%s_data%0d", tag, k), rData, expWords[k]);
            if (k == abortWord) begin
                rst_n = 1'b0;
                #1;
                checkOutput({tag, "_rst_data"}, rData, 32'd0);
                checkOutput({tag, "_rst_valid"}, {31'b0, rValid}, 32'd0);
                checkOutput({tag, "_rst_init"}, {31'b0, initDone}, 32'd0);
                checkOutput({tag, "_rst_ack"}, {31'b0, ack}, 32'd0);
                return;
            end
        end
        tick();
        checkOutput({tag, "_valid_end"}, {31'b0, rValid}, 32'd0);
        checkOutput({tag, "_data_hold"}, rData, expWords[l]);
    endtask

    task automatic waitInit(input string tag);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= Init; i++) begin
            tick();
            checkOutput($sformatf("%s_init_c%0d", tag, i), {31'b0, initDone}, {31'b0, (i >= Init)});
            checkOutput($sformatf("%s_noack_c%0d", tag, i), {31'b0, ack}, 32'd0);
        end
    endtask

    initial begin
        // Reset values are checked before the clock has ticked.
        #1;
        checkOutput("reset_data", rData, 32'd0);
        checkOutput("reset_init", {31'b0, initDone}, 32'd0);
        checkOutput("reset_valid", {31'b0, rValid}, 32'd0);

        applyStimulus(CmdRead, 21'h10, 8'd0);
        waitInit("boot");
        cmdEn = 1'b0;

        for (int k = 0; k < 4; k++) begin
            wrWords[k]  = 32'hA0 + k;
            wrMask[k]   = 4'h0;
            expWords[k] = 32'hA0 + k;
        end
        writeBurst(21'h10, 8'd3, "wr10");
        readBurst(21'h10, 8'd3, -1, "rd10");

        vecs[0] = '{1'b1, 21'h20, 32'hFFFFFFFF, 4'b0000, 32'h0, "w20_ones"};
        vecs[1] = '{1'b1, 21'h20, 32'h12345678, 4'b0101, 32'h0, "w20_mask"};
        vecs[2] = '{1'b0, 21'h20, 32'h0, 4'b0000, 32'h12FF56FF, "r20"};
        vecs[3] = '{1'b1, 21'h21, 32'hDEADBEEF, 4'b0000, 32'h0, "w21_full"};
        vecs[4] = '{1'b1, 21'h21, 32'h00000000, 4'b1111, 32'h0, "w21_allmask"};
        vecs[5] = '{1'b0, 21'h21, 32'h0, 4'b0000, 32'hDEADBEEF, "r21_a"};
        vecs[6] = '{1'b1, 21'h21, 32'h11223344, 4'b1010, 32'h0, "w21_mask"};
        vecs[7] = '{1'b0, 21'h21, 32'h0, 4'b0000, 32'hDE22BE44, "r21_b"};
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].isWrite) begin
                wrWords[0] = vecs[v].data;
                wrMask[0]  = vecs[v].dqm;
                writeBurst(vecs[v].addr, 8'd0, vecs[v].name);
            end else begin
                expWords[0] = vecs[v].expData;
                readBurst(vecs[v].addr, 8'd0, -1, vecs[v].name);
            end
        end

        wrWords[0] = 32'h1;
        wrWords[1] = 32'h2;
        wrMask[0]  = 4'h0;
        wrMask[1]  = 4'h0;
        writeBurst(21'h0FFFF, 8'd1, "wrwrap");
        expWords[0] = 32'h2;
        readBurst(21'h00000, 8'd0, -1, "rdwrap0");
        expWords[0] = 32'h1;
        readBurst(21'h1FFFF, 8'd0, -1, "rdalias");
        expWords[0] = 32'h1;
        expWords[1] = 32'h2;
        readBurst(21'h0FFFF, 8'd1, -1, "rdwrapburst");

        // Strobe a read every cycle from the refresh ack on; only the first strobe after the busy window may be acked.
        issueCmd(CmdRefresh, 21'h0, 8'd0, "refresh");
        applyStimulus(CmdRead, 21'h10, 8'd0);
        for (int c = 1; c <= Busy + 1; c++) begin
            tick();
            checkOutput($sformatf("busy_ack_c%0d", c), {31'b0, ack}, {31'b0, (c == Busy + 1)});
        end
        cmdEn = 1'b0;
        for (int c = 0; c < RL; c++) tick();
        checkOutput("busy_rd_valid", {31'b0, rValid}, 32'd1);
        checkOutput("busy_rd_data", rData, 32'hA0);
        tick();
        checkOutput("busy_rd_done", {31'b0, rValid}, 32'd0);

        for (int k = 0; k < 8; k++) begin
            wrWords[k]  = 32'hB0 + k;
            wrMask[k]   = 4'h0;
            expWords[k] = 32'hB0 + k;
        end
        writeBurst(21'h40, 8'd7, "wr40");
        readBurst(21'h40, 8'd7, 2, "rdabort");
        waitInit("reinit");
        readBurst(21'h40, 8'd7, -1, "rd40");
        for (int k = 0; k < 4; k++) expWords[k] = 32'hA0 + k;
        readBurst(21'h10, 8'd3, -1, "rd10_again");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdrc_responder.md
Name: sdrc_responder

Overview:
- Behavioural, synthesizable responder for the SDRAM-controller user interface (I_sdrc_*/O_sdrc_*) that ramio drives.
- Backed by an internal word array. Replaces SDRAM_Controller_HS_Top + sdr2mx32 in fast QA benches, removing the ~328 us SDRAM init wait.
- Same port names and command encoding as the controller interface, with deterministic, parameterised timing.

Parameters:
- MemAddressBitwidth, 16, log2 of word-array depth; I_sdrc_addr is used modulo 2^MemAddressBitwidth.
- InitCycles, 16, cycles after reset release before O_sdrc_init_done rises.
- ReadLatency, 3, cycles from the cmd_ack cycle to the first read word.
- CmdBusyCycles, 4, cycles a non-data command keeps the block busy after ack.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- I_sdrc_cmd_en  input  1  command strobe.
- I_sdrc_cmd  input  3  command: 000 MRS, 001 refresh, 010 precharge, 011 activate, 100 write, 101 read, 111 NOP.
- I_sdrc_precharge_ctrl  input  1  ignored.
- I_sdram_power_down  input  1  ignored.
- I_sdram_selfrefresh  input  1  ignored.
- I_sdrc_addr  input  21  word address.
- I_sdrc_dqm  input  4  byte mask; bit=1 means the byte is not written.
- I_sdrc_data  input  32  write data.
- I_sdrc_data_len  input  8  burst length minus one (1..256 words).
- O_sdrc_data  output  32  read data.
- O_sdrc_init_done  output  1  initialisation complete.
- O_sdrc_cmd_ack  output  1  one-cycle command acknowledge.
- read_valid  output  1  high while O_sdrc_data carries a burst word (bench aid).

Behaviour:
- Reset values: O_sdrc_data=0, O_sdrc_init_done=0, O_sdrc_cmd_ack=0, read_valid=0, state INIT. Memory contents are not cleared.
- States: INIT, IDLE, WRITE, READ_WAIT, READ, BUSY.
- INIT: a counter runs InitCycles. Then init_done=1 (stays 1 until reset) and the state goes to IDLE.
  - cmd_en during INIT is ignored and never acked.
- IDLE, cycle T with cmd_en=1:
  - Latch addr, len and cmd.
  - O_sdrc_cmd_ack=1 at T+1 only.
  - NOP (111) is never acked and never changes state.
  - Undefined cmd 110 is treated as NOP.
- Write (100):
  - Word k (k=0..len) is sampled from I_sdrc_data/I_sdrc_dqm at cycle T+1+k.
  - Masked bytes keep their old value.
  - State WRITE for len+1 cycles, then IDLE.
- Read (101):
  - READ_WAIT for ReadLatency cycles.
  - Word k is driven on O_sdrc_data at cycle T+1+ReadLatency+k with read_valid=1.
  - Then IDLE.
  - O_sdrc_data holds the last word afterwards.
- Address increments by 1 per word and wraps modulo 2^MemAddressBitwidth.
  - Address bits above MemAddressBitwidth are ignored.
- MRS/refresh/precharge/activate: acked at T+1, then BUSY for CmdBusyCycles cycles, then IDLE. No memory effect.
- cmd_en while not IDLE (including the ack cycle) is ignored: no ack, no queueing. The initiator must re-issue.
- Earliest next accepted command: the cycle after the state returns to IDLE.
- Read latency counts from the ack cycle. A write issued immediately after a read returns the pre-write data for that read.
- Asynchronous reset mid-burst:
  - Abort immediately; outputs go to reset values; state INIT.
  - Write words already committed remain in memory.

Decomposition:
- Package sdrc_pkg holds:
  - command constants (CmdMrs, CmdRefresh, CmdPrecharge, CmdActivate, CmdWrite, CmdRead, CmdNop);
  - state enum;
  - interface widths (address 21, data 32, dqm 4, len 8).
- One sub-module, sdrc_responder_mem: byte-enabled, single-port, synchronous-read word array of depth 2^MemAddressBitwidth. It supplies the 1-cycle read that sits inside ReadLatency, so ReadLatency>=1 is required.

Test Plan:
- Reset, then poll with cmd_en=1 during INIT -> init_done rises exactly InitCycles cycles after rst_n release; no ack before that.
- Write addr=0x10, len=3, data 0xA0..0xA3, dqm=0; then read addr=0x10, len=3 -> ack at T+1; read_valid for 4 cycles starting T+1+3; data 0xA0,0xA1,0xA2,0xA3.
- Write 0xFFFFFFFF to 0x20; then write 0x12345678 with dqm=0b0101 -> read back 0x12FF56FF.
- Write len=1 at addr=0xFFFF (MemAddressBitwidth=16), data 0x1, 0x2 -> read 0x0000 returns 0x2; addr 0x1FFFF aliases 0xFFFF and returns 0x1.
- Refresh, then read issued on the ack cycle and every following cycle -> only the read issued when the state is back in IDLE (refresh ack + CmdBusyCycles) is acked; earlier strobes get no ack.
- Assert rst_n=0 at the third word of a len=7 read -> outputs 0 and init_done 0 immediately; after InitCycles, init_done=1 and the previously written data is intact.
